// File: rtl/instr_decoder.sv
// Decode stage for the 16-bit Harvard processor.
// A packed 32-bit instruction word is unpacked into register, immediate,
// address and ALU-control fields. An output register (OR) holds the decoded
// bundle and a skid register (SR) holds one raw word. This gives full
// throughput while letting back-pressure reach fetch through a registered
// in_ready. Two counters track delivered bundles and delivered illegal bundles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload until that edge. The DUT
// holds out_valid and every bundle field stable while out_valid && !out_ready.
// in_ready depends only on registered state and flush, so it never depends
// combinationally on in_valid.
module instr_decoder #(
    parameter logic [5:0] OPC_MAX = 6'h10,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rdst2,
    output logic [4:0]       rdst1,
    output logic [4:0]       rsrc2,
    output logic [4:0]       rsrc1,
    output logic [15:0]      imm,
    output logic [7:0]       mem_addr,
    output logic [3:0]       alu_op,
    output logic [2:0]       fmt,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [7:0]       illegal_count
);

    typedef enum logic [2:0] {
        FMT_LDI     = 3'd0,
        FMT_MOV     = 3'd1,
        FMT_LD      = 3'd2,
        FMT_ST      = 3'd3,
        FMT_ALU     = 3'd4,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rdst2;
        logic [4:0]  rdst1;
        logic [4:0]  rsrc2;
        logic [4:0]  rsrc1;
        logic [15:0] imm;
        logic [7:0]  mem_addr;
        logic [3:0]  alu_op;
        fmt_e        fmt;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
    } bundle_t;

    localparam logic [5:0] OPC_LDI     = 6'h00;
    localparam logic [5:0] OPC_MOV     = 6'h01;
    localparam logic [5:0] OPC_LD      = 6'h02;
    localparam logic [5:0] OPC_ST      = 6'h03;
    localparam logic [5:0] OPC_ALU_LO  = 6'h04;
    localparam logic [5:0] OPC_ALU_HI  = 6'h10;
    localparam logic [7:0] ILL_CNT_MAX = 8'hFF;

    // Registered state
    bundle_t            or_q, or_d;
    logic               or_valid_q, or_valid_d;
    logic [31:0]        sr_word_q, sr_word_d;
    logic               sr_valid_q, sr_valid_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic [7:0]         illegal_count_q, illegal_count_d;

    // Datapath helpers
    logic [31:0]        dec_src;
    bundle_t            dec;
    logic [5:0]         dec_opc;
    logic [5:0]         alu_full;
    logic               accept;
    logic               deliver;

    // Ready only when the skid slot is free and no flush is in progress.
    always_comb begin
        in_ready = !sr_valid_q && !flush;
        accept   = in_valid && in_ready;
        deliver  = or_valid_q && out_ready;
    end

    // Choose the decode source. A full SR blocks accepts, so in_instr is
    // never needed in the same cycle that SR drains into OR.
    always_comb begin
        dec_src = sr_valid_q ? sr_word_q : in_instr;
    end

    // Combinational field unpacking of the selected source word.
    always_comb begin
        dec      = '0;
        dec_opc  = dec_src[31:26];
        alu_full = dec_opc - OPC_ALU_LO;

        dec.opcode  = dec_opc;
        dec.rdst2   = dec_src[25:21];
        dec.rdst1   = dec_src[20:16];
        dec.rsrc2   = dec_src[9:5];
        dec.rsrc1   = dec_src[4:0];
        dec.imm     = dec_src[15:0];
        dec.illegal = (dec_opc > OPC_MAX);

        // MOV and ST carry their second source in the low register slot.
        if (dec_opc == OPC_MOV || dec_opc == OPC_ST) begin
            dec.rsrc2 = dec_src[4:0];
        end

        // LD takes a low-byte address; ST packs its address above the
        // register fields, mirroring the data-memory word writer.
        if (dec_opc == OPC_LD) begin
            dec.mem_addr = dec_src[7:0];
        end else if (dec_opc == OPC_ST) begin
            dec.mem_addr = dec_src[25:18];
        end

        if (dec_opc >= OPC_ALU_LO && dec_opc <= OPC_ALU_HI) begin
            dec.alu_op = alu_full[3:0];
        end

        // Format and control strobes. Opcodes without a format, and anything
        // flagged illegal, produce no side effects.
        dec.fmt = FMT_ILLEGAL;
        if (!dec.illegal) begin
            if (dec_opc == OPC_LDI) begin
                dec.fmt    = FMT_LDI;
                dec.reg_we = 1'b1;
            end else if (dec_opc == OPC_MOV) begin
                dec.fmt    = FMT_MOV;
                dec.reg_we = 1'b1;
            end else if (dec_opc == OPC_LD) begin
                dec.fmt    = FMT_LD;
                dec.reg_we = 1'b1;
                dec.mem_rd = 1'b1;
            end else if (dec_opc == OPC_ST) begin
                dec.fmt    = FMT_ST;
                dec.mem_wr = 1'b1;
            end else if (dec_opc >= OPC_ALU_LO && dec_opc <= OPC_ALU_HI) begin
                dec.fmt    = FMT_ALU;
                dec.reg_we = 1'b1;
            end
        end
    end

    // Next-state for the OR/SR pair: drain SR first, else load the new word
    // into OR when it is free or draining, else park the word in SR.
    always_comb begin
        or_d       = or_q;
        or_valid_d = or_valid_q;
        sr_word_d  = sr_word_q;
        sr_valid_d = sr_valid_q;

        if (flush) begin
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (sr_valid_q && out_ready) begin
            or_d       = dec;
            or_valid_d = 1'b1;
            sr_valid_d = 1'b0;
        end else if (accept && (!or_valid_q || out_ready)) begin
            or_d       = dec;
            or_valid_d = 1'b1;
        end else if (accept) begin
            sr_word_d  = in_instr;
            sr_valid_d = 1'b1;
        end else if (deliver) begin
            or_valid_d = 1'b0;
        end
    end

    // Delivery counters; a handshake in a flush cycle still counts.
    always_comb begin
        instr_count_d   = instr_count_q;
        illegal_count_d = illegal_count_q;
        if (deliver) begin
            instr_count_d = instr_count_q + 1'b1;
            if (or_q.illegal && illegal_count_q != ILL_CNT_MAX) begin
                illegal_count_d = illegal_count_q + 8'd1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q            <= '0;
            or_valid_q      <= 1'b0;
            sr_word_q       <= '0;
            sr_valid_q      <= 1'b0;
            instr_count_q   <= '0;
            illegal_count_q <= '0;
        end else begin
            or_q            <= or_d;
            or_valid_q      <= or_valid_d;
            sr_word_q       <= sr_word_d;
            sr_valid_q      <= sr_valid_d;
            instr_count_q   <= instr_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    // Output drive straight from the registered bundle.
    always_comb begin
        out_valid     = or_valid_q;
        opcode        = or_q.opcode;
        rdst2         = or_q.rdst2;
        rdst1         = or_q.rdst1;
        rsrc2         = or_q.rsrc2;
        rsrc1         = or_q.rsrc1;
        imm           = or_q.imm;
        mem_addr      = or_q.mem_addr;
        alu_op        = or_q.alu_op;
        fmt           = or_q.fmt;
        reg_we        = or_q.reg_we;
        mem_rd        = or_q.mem_rd;
        mem_wr        = or_q.mem_wr;
        illegal       = or_q.illegal;
        instr_count   = instr_count_q;
        illegal_count = illegal_count_q;
    end

endmodule
